// File: rtl/posit_mul_host.sv
// Initiator for the posit_mul start/done handshake: takes operand pairs from a
// valid/ready stream, issues one multiply at a time and returns the result or NaR on timeout.
module posit_mul_host #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_result,
  input  logic        mul_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_timeout,
  output logic        busy,
  output logic [15:0] txn_count
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TXN_W  = 16;
  localparam logic [DATA_W-1:0] NAR      = 32'h8000_0000;
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e             state_q;
  logic               mul_start_q;
  logic [DATA_W-1:0]  mul_a_q;
  logic [DATA_W-1:0]  mul_b_q;
  logic               out_valid_q;
  logic [DATA_W-1:0]  out_result_q;
  logic               out_timeout_q;
  logic [TXN_W-1:0]   txn_count_q;
  logic [CNT_W-1:0]   timer_q;
  logic               done_q;
  logic               done_rise;

  // Only a fresh rising edge of done counts; a level left over from a prior op does not.
  assign done_rise = mul_done & ~done_q;

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign mul_start   = mul_start_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_timeout = out_timeout_q;
  assign txn_count   = txn_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      mul_start_q   <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_timeout_q <= 1'b0;
      txn_count_q   <= '0;
      timer_q       <= '0;
      done_q        <= 1'b0;
    end else begin
      done_q      <= mul_done;
      mul_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            mul_a_q     <= in_a;
            mul_b_q     <= in_b;
            mul_start_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // Completion takes priority over a timeout landing in the same cycle.
          if (done_rise) begin
            out_result_q  <= mul_result;
            out_timeout_q <= 1'b0;
            out_valid_q   <= 1'b1;
            state_q       <= S_HOLD;
          end else if (timer_q == TMO_LAST) begin
            out_result_q  <= NAR;
            out_timeout_q <= 1'b1;
            out_valid_q   <= 1'b1;
            state_q       <= S_HOLD;
          end else begin
            timer_q <= timer_q + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            txn_count_q <= txn_count_q + TXN_W'(1);
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
